i2s_frame_tx: RTL and testbench

Parallel-to-I2S serializer that generates the `ws`/`sd` stream consumed by the on-chip I2S receiver/parity stage. It accepts one stereo sample pair (left, right) per frame through a valid/ready handshake and buffers one pair ahead of the frame being shifted out. It emits standard Philips I2S with MSB first, one-bit delay after each `ws` edge, `ws`=0 for left and `ws`=1 for right. It substitutes a zero frame and flags underrun when no sample is available.

---
 rtl/i2s_frame_tx_if.sv | 22 ++
 rtl/i2s_frame_tx.sv | 111 +++++++++++
 tb/tb_i2s_frame_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/i2s_frame_tx_if.sv
// Sample-pair handshake plus I2S output signals of the frame serializer.
interface i2s_frame_tx_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;
  logic             in_valid;
  logic             in_ready;
  logic             ws;
  logic             sd;
  logic             frame_start;
  logic             underrun;

  modport master (
    output en, left_in, right_in, in_valid,
    input  in_ready, ws, sd, frame_start, underrun
  );

  modport slave (
    input  en, left_in, right_in, in_valid,
    output in_ready, ws, sd, frame_start, underrun
  );
endinterface

// File: rtl/i2s_frame_tx.sv
// Philips I2S serializer: one buffered stereo pair ahead of the shifting frame,
// zero frame plus underrun pulse when the buffer is empty at a frame load.
module i2s_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic sck,
  input  logic rst,
  i2s_frame_tx_if.slave bus
);
  localparam int FW = 2 * WIDTH;
  localparam int CW = $clog2(FW);
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [FW-1:0] buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic          fs_q, fs_d;
  logic          ur_q, ur_d;
  logic          load, accept;

  always_comb begin
    accept  = bus.in_valid & ~buf_full_q;
    load    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sd_d    = sd_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sd_d  = 1'b0;
        sh_d  = '0;
        if (bus.en) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // MSB of the shifter is the next bit; at the wrap it is R[0] of this frame
        sd_d = sh_q[FW-1];
        sh_d = {sh_q[FW-2:0], 1'b0};
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bus.en) load = 1'b1;
          else        state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sd_d    = 1'b0;
        sh_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sd_d    = 1'b0;
        sh_d    = '0;
      end
    endcase
    if (load) sh_d = buf_full_q ? buf_q : '0;

    ws_d       = (state_d == S_RUN) && (cnt_d >= CNT_HALF);
    buf_d      = accept ? {bus.left_in, bus.right_in} : buf_q;
    // in_ready is low whenever full, so accept at a load only refills an emptied buffer
    buf_full_d = load ? accept : (buf_full_q | accept);
    fs_d       = load;
    ur_d       = load & ~buf_full_q;
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign bus.in_ready    = ~buf_full_q;
  assign bus.ws          = ws_q;
  assign bus.sd          = sd_q;
  assign bus.frame_start = fs_q;
  assign bus.underrun    = ur_q;
endmodule

// File: tb/tb_i2s_frame_tx.sv
// Scoreboard bench for i2s_frame_tx (WIDTH=8): stimulus queues per-cycle
// expected {ws,sd,frame_start,underrun,in_ready}; a negedge monitor checks them.
module tb_i2s_frame_tx;
  localparam int W = 8;

  logic sck = 1'b0;
  logic rst = 1'b1;

  i2s_frame_tx_if #(.WIDTH(W)) bus ();

  i2s_frame_tx #(.WIDTH(W)) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 sck = ~sck;

  logic [4:0] expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int idx   = 0;

  always @(negedge sck) begin
    if (expq.size() > 0) begin
      logic [4:0] e, g;
      e = expq.pop_front();
      g = {bus.ws, bus.sd, bus.frame_start, bus.underrun, bus.in_ready};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL chk%0d {ws,sd,fs,ur,rdy}: got %b want %b at %0t", idx, g, e, $time);
      end
      idx++;
    end
  end

  task automatic step(input logic ws, sd, fs, ur, rdy);
    @(posedge sck);
    #1;
    expq.push_back({ws, sd, fs, ur, rdy});
  endtask

  task automatic offer(input logic [W-1:0] l, r);
    bus.left_in  = l;
    bus.right_in = r;
    bus.in_valid = 1'b1;
  endtask

  // One 16-cycle frame; offers (nl,nr) after cycle acc_at, drops en after cycle en_off.
  task automatic frame(input logic [W-1:0] l, r, input logic prev0, ur, rdy0,
                       input int acc_at, input logic [W-1:0] nl, nr, input int en_off);
    logic [2*W-1:0] s;
    logic rdy;
    s   = {l, r};
    rdy = rdy0;
    for (int c = 0; c < 2*W; c++) begin
      step(c >= W, (c == 0) ? prev0 : s[2*W-c], c == 0, (c == 0) && ur, rdy);
      bus.in_valid = 1'b0;
      if (c == acc_at) begin
        offer(nl, nr);
        rdy = 1'b0;
      end
      if (c == en_off) bus.en = 1'b0;
    end
  endtask

  initial begin
    logic [16:0] seq;
    bus.en       = 1'b0;
    bus.left_in  = '0;
    bus.right_in = '0;
    bus.in_valid = 1'b0;

    // reset state
    repeat (2) @(posedge sck);
    #1 expq.push_back(5'b00001);
    rst = 1'b0;
    step(0, 0, 0, 0, 1);

    // single frame L=A5 R=01, prefilled while idle
    seq = 17'b0_10100101_0000000_1;
    offer(8'hA5, 8'h01);
    step(0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    for (int k = 0; k < 2*W; k++) begin
      step(k >= W, seq[16-k], k == 0, 1'b0, 1'b1);
      if (k == 0) bus.en = 1'b0;
    end
    step(0, seq[0], 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // back-to-back, underrun, offer on underrun load, stop mid-frame
    offer(8'hFF, 8'h00);
    step(0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    frame(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 2,  8'h00, 8'hFF, -1);
    frame(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, -1, 8'h00, 8'h00, -1);
    frame(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 15, 8'h3C, 8'h81, -1);
    frame(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, -1, 8'h00, 8'h00, -1);
    frame(8'h3C, 8'h81, 1'b0, 1'b0, 1'b1, -1, 8'h00, 8'h00, 5);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // asynchronous reset mid-frame discards buffer and frame
    offer(8'h5A, 8'hC3);
    step(0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    @(posedge sck);
    #3 rst = 1'b1;
    #1 expq.push_back(5'b00001);
    bus.en = 1'b0;
    step(0, 0, 0, 0, 1);
    rst = 1'b0;
    step(0, 0, 0, 0, 1);
    bus.en = 1'b1;
    frame(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, -1, 8'h00, 8'h00, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    repeat (3) @(negedge sck);
    #1;
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: got %0d pending want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
